// File: rtl/jvm_useq_pkg.sv
// Shared definitions for the JVM micro-PC sequencer: address widths, markers,
// FSM state encoding and error codes.
package jvm_useq_pkg;

  localparam int UADR_W = 9;
  localparam int UADR_LAST = 320;

  localparam logic [UADR_W-1:0] UADR_END = 9'h000;
  localparam logic [UADR_W-1:0] UADR_INVALID = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } useq_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_STEPS = 2'd2;

endpackage

// File: rtl/jvm_microsequencer_if.sv
// Bytecode intake, next-address ROM lookup and micro-op output bundle.
// The master modport is the sequencer's view; slave is the surrounding engine.
interface jvm_microsequencer_if #(
  parameter int UADR_W = jvm_useq_pkg::UADR_W
) ();

  logic              bc_valid;
  logic [7:0]        bc_opcode;
  logic              bc_ready;
  logic [UADR_W-1:0] rom_adr;
  logic [UADR_W-1:0] rom_next;
  logic              uop_valid;
  logic [UADR_W-1:0] uop_adr;
  logic              uop_first;
  logic              uop_last;
  logic              uop_ready;

  modport master (
    input  bc_valid, bc_opcode, rom_next, uop_ready,
    output bc_ready, rom_adr, uop_valid, uop_adr, uop_first, uop_last
  );

  modport slave (
    output bc_valid, bc_opcode, rom_next, uop_ready,
    input  bc_ready, rom_adr, uop_valid, uop_adr, uop_first, uop_last
  );

endinterface

// File: rtl/jvm_microsequencer.sv
// Micro-PC sequencer: dispatches a Java opcode to micro-address {0,opcode} and
// follows next_adr_rom continuations until the end marker, flagging bad walks.
module jvm_microsequencer
  import jvm_useq_pkg::*;
#(
  parameter int UADR_W    = jvm_useq_pkg::UADR_W,
  parameter int UADR_LAST = jvm_useq_pkg::UADR_LAST,
  parameter int MAX_STEPS = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  jvm_microsequencer_if.master        bus,
  output logic                        busy,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [UADR_W-1:0] LAST_ADR = UADR_W'(UADR_LAST);
  localparam logic [UADR_W-1:0] FIRST_LIMIT = UADR_W'(256);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  useq_state_t       state_r, state_s;
  logic [UADR_W-1:0] upc_r, upc_s;
  logic [STEP_W-1:0] step_r, step_s;
  logic [1:0]        err_code_r, err_code_s;
  logic              fire_s;

  assign fire_s        = (state_r == EXEC) && bus.uop_ready;

  assign bus.bc_ready  = (state_r == IDLE);
  assign bus.uop_valid = (state_r == EXEC);
  assign bus.uop_adr   = upc_r;
  assign bus.rom_adr   = upc_r;
  assign bus.uop_first = (upc_r < FIRST_LIMIT);
  assign bus.uop_last  = (bus.rom_next == UADR_END);
  assign busy          = (state_r != IDLE);
  assign err           = (state_r == ERROR);
  assign err_code      = err_code_r;

  // State, micro-PC, step counter and error code registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      upc_r      <= '0;
      step_r     <= '0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_s;
      upc_r      <= upc_s;
      step_r     <= step_s;
      err_code_r <= err_code_s;
    end
  end

  // Next-state decode; continuations are only examined when the emitter takes the uop.
  always_comb begin
    state_s    = state_r;
    upc_s      = upc_r;
    step_s     = step_r;
    err_code_s = err_code_r;
    case (state_r)
      IDLE: begin
        if (bus.bc_valid) begin
          state_s = EXEC;
          upc_s   = {{(UADR_W-8){1'b0}}, bus.bc_opcode};
          step_s  = STEP_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (fire_s) begin
          if (bus.rom_next == UADR_END) begin
            state_s = IDLE;
          end else if (bus.rom_next > LAST_ADR) begin
            state_s    = ERROR;
            err_code_s = ERR_ILLEGAL;
          end else if (step_r >= STEP_MAX) begin
            state_s    = ERROR;
            err_code_s = ERR_STEPS;
          end else begin
            upc_s  = bus.rom_next;
            step_s = step_r + STEP_ONE;
          end
        end else begin
          state_s = EXEC;
        end
      end
      ERROR: begin
        state_s = ERROR;
      end
      default: begin
        state_s = ERROR;
      end
    endcase
  end

endmodule

// File: tb/tb_jvm_microsequencer.sv
// Scoreboard bench for jvm_microsequencer with a behavioural next_adr_rom and stub modes.
module tb_jvm_microsequencer;
  import jvm_useq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  int         rom_mode = 0;
  int         n_pass = 0;
  int         n_total = 0;

  typedef struct {
    logic [8:0] adr;
    logic       first;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  jvm_microsequencer_if bus ();

  jvm_microsequencer #(.UADR_W(9), .UADR_LAST(320), .MAX_STEPS(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err), .err_code(err_code)
  );

  // mode 0: real table, 1: 89 returns invalid marker, 2: 16 -> 300 -> 300 loop
  function automatic logic [8:0] rom_f(input logic [8:0] a, input int mode);
    if (mode == 1 && a == 9'd89) return 9'h1FF;
    if (mode == 2 && (a == 9'd16 || a == 9'd300)) return 9'd300;
    case (a)
      9'd89:   return 9'd256;
      9'd256:  return 9'd257;
      9'd257:  return 9'd0;
      9'd11:   return 9'd268;
      9'd268:  return 9'd0;
      default: return (a < 9'd256) ? 9'd0 : 9'h1FF;
    endcase
  endfunction

  always_comb bus.rom_next = rom_f(bus.rom_adr, rom_mode);

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int adr, input bit first, input bit last);
    exp_t e;
    e.adr = 9'(adr);
    e.first = first;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: every consumed uop must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.uop_valid && bus.uop_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL uop_unexpected: got adr %0d expected none", bus.uop_adr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("uop_adr", int'(bus.uop_adr), int'(e.adr));
        check("uop_first", int'(bus.uop_first), int'(e.first));
        check("uop_last", int'(bus.uop_last), int'(e.last));
      end
    end
  end

  task automatic send(input logic [7:0] op);
    int n;
    bus.bc_opcode = op;
    bus.bc_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.bc_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("bc_accept", int'(bus.bc_ready), 1);
    @(posedge clk);
    #1;
    bus.bc_valid = 1'b0;
    check("dispatch_valid", int'(bus.uop_valid), 1);
    check("dispatch_adr", int'(bus.uop_adr), int'(op));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("back_to_idle", int'(busy), 0);
    check("idle_bc_ready", int'(bus.bc_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_err();
    int n;
    n = 0;
    @(negedge clk);
    while (!err && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("err_raised", int'(err), 1);
  endtask

  task automatic reach_256();
    int n;
    n = 0;
    while (bus.uop_adr != 9'd256 && n < 10) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("reach_256", int'(bus.uop_adr), 256);
  endtask

  task automatic do_reset(input int mode);
    rst_n = 1'b0;
    rom_mode = mode;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.bc_valid = 1'b0;
    bus.bc_opcode = 8'h00;
    bus.uop_ready = 1'b1;
    do_reset(0);
    @(negedge clk);
    check("rst_bc_ready", int'(bus.bc_ready), 1);
    check("rst_uop_valid", int'(bus.uop_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    @(posedge clk);
    #1;

    // dup: three-step walk
    push(89, 1'b1, 1'b0); push(256, 1'b0, 1'b0); push(257, 1'b0, 1'b1);
    send(8'h59);
    wait_idle();

    push(11, 1'b1, 1'b0); push(268, 1'b0, 1'b1);
    send(8'h0B);
    wait_idle();
    push(42, 1'b1, 1'b1);
    send(8'h2A);
    wait_idle();

    // stall three cycles on 256
    push(89, 1'b1, 1'b0); push(256, 1'b0, 1'b0); push(257, 1'b0, 1'b1);
    send(8'h59);
    reach_256();
    bus.uop_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_adr", int'(bus.uop_adr), 256);
      check("stall_valid", int'(bus.uop_valid), 1);
    end
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b1;
    check("post_stall_adr", int'(bus.uop_adr), 256);
    wait_idle();

    push(255, 1'b1, 1'b1);
    send(8'hFF);
    wait_idle();

    // illegal continuation
    rom_mode = 1;
    push(89, 1'b1, 1'b0);
    send(8'h59);
    wait_err();
    check("illegal_code", int'(err_code), 1);
    bus.bc_opcode = 8'h2A;
    bus.bc_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("err_uop_valid", int'(bus.uop_valid), 0);
      check("err_bc_ready", int'(bus.bc_ready), 0);
      check("err_sticky", int'(err), 1);
      check("err_busy", int'(busy), 1);
    end
    bus.bc_valid = 1'b0;
    check("illegal_q_empty", exp_q.size(), 0);
    do_reset(2);
    @(negedge clk);
    check("reset_clears_err", int'(err), 0);
    check("reset_clears_code", int'(err_code), 0);
    @(posedge clk);
    #1;

    // runaway self-loop: 64 uops then step overflow
    push(16, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) push(300, 1'b0, 1'b0);
    send(8'h10);
    wait_err();
    check("steps_code", int'(err_code), 2);
    check("steps_uop_valid", int'(bus.uop_valid), 0);
    check("steps_q_empty", exp_q.size(), 0);
    do_reset(0);

    // reset in mid-sequence
    push(89, 1'b1, 1'b0);
    send(8'h59);
    reach_256();
    bus.uop_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_uop_valid", int'(bus.uop_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_q_empty", exp_q.size(), 0);
    rst_n = 1'b1;
    bus.uop_ready = 1'b1;
    push(11, 1'b1, 1'b0); push(268, 1'b0, 1'b1);
    send(8'h0B);
    wait_idle();
    check("final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
